// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file with prioritised write-back, same-cycle bypass
// and a per-register busy scoreboard for decode hazard detection.
module regfile_mp_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_wa,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DW-1:0]    rf [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic             w0_ok;
    logic             w1_ok;

    // Port 1 loses a same-address collision, so it never commits then.
    assign w0_ok = we0 && !(ZR && wa0 == '0);
    assign w1_ok = we1 && !(ZR && wa1 == '0) && !(w0_ok && wa0 == wa1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (w0_ok) begin
                rf[wa0] <= wd0;
            end
            if (w1_ok) begin
                rf[wa1] <= wd1;
            end
        end
    end

    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            logic          hit0;
            logic          hit1;
            a    = ra[k*AW +: AW];
            hit0 = we0 && wa0 == a;
            hit1 = we1 && wa1 == a;
            if (ZR && a == '0) begin
                rd[k*DW +: DW] = '0;
            end else if (hit0) begin
                rd[k*DW +: DW] = wd0;
            end else if (hit1) begin
                rd[k*DW +: DW] = wd1;
            end else begin
                rd[k*DW +: DW] = rf[a];
            end
            rd_busy[k] = busy[a] && !hit0 && !hit1 && !(ZR && a == '0);
        end
    end

    // Issue wins over write-back and flush so a fresh producer is tracked.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i)) || flush) begin
                busy_nxt[i] = 1'b0;
            end
            if (iss_valid && iss_wa == AW'(i)) begin
                busy_nxt[i] = 1'b1;
            end
        end
        if (ZR) begin
            busy_nxt[0] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (AW + 1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomised and directed bench for regfile_mp_sb against an
// array-based reference model of register contents and busy flags.
module tb_regfile_mp_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int N   = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1, iss_valid, flush;
    logic [AW-1:0]     wa0, wa1, iss_wa;
    logic [DW-1:0]     wd0, wd1;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;
    logic [NRD-1:0]    rd_busy;
    logic [AW:0]       busy_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] mrf [N];
    bit            mbusy [N];

    regfile_mp_sb #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_wa(iss_wa),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; we0 = 0; we1 = 0; iss_valid = 0; flush = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_wa = '0;
    endtask

    task automatic ra_all(input logic [AW-1:0] a);
        ra = {NRD{a}};
    endtask

    function automatic logic [DW-1:0] m_rd(input int a);
        if (a == 0) return '0;
        if (we0 && int'(wa0) == a) return wd0;
        if (we1 && int'(wa1) == a) return wd1;
        return mrf[a];
    endfunction

    function automatic bit m_busy(input int a);
        if (a == 0) return 1'b0;
        if (we0 && int'(wa0) == a) return 1'b0;
        if (we1 && int'(wa1) == a) return 1'b0;
        return mbusy[a];
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mrf[i] = '0;
                mbusy[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((we0 && int'(wa0) == i) || (we1 && int'(wa1) == i) || flush)
                    mbusy[i] = 0;
                if (iss_valid && int'(iss_wa) == i)
                    mbusy[i] = 1;
            end
            mbusy[0] = 0;
            if (we1 && wa1 != 0) mrf[wa1] = wd1;
            if (we0 && wa0 != 0) mrf[wa0] = wd0;
        end
    endtask

    // Called 1 time unit after a posedge with inputs already driven.
    task automatic tick();
        #2;
        if (!rst) begin
            for (int k = 0; k < NRD; k++) begin
                int a;
                a = int'(ra[k*AW +: AW]);
                chk($sformatf("rd%0d_r%0d", k, a), 64'(rd[k*DW +: DW]), 64'(m_rd(a)));
                chk($sformatf("busy%0d_r%0d", k, a), 64'(rd_busy[k]), 64'(m_busy(a)));
            end
            chk("busy_cnt", 64'(busy_cnt), 64'(m_cnt()));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        idle();
        ra_all('0);
        rst = 1;
        @(posedge clk);
        #1;
        tick();
        idle();

        // reset state on every register and port
        for (int a = 0; a < N; a++) begin
            ra_all(AW'(a));
            #1;
            chk("t1_rd", 64'(rd[DW-1:0]), 64'h0);
            chk("t1_busy", 64'(rd_busy), 64'h0);
            tick();
        end
        chk("t1_cnt", 64'(busy_cnt), 64'h0);

        // bypass then hold
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra_all(5);
        #1 chk("t2_byp", 64'(rd[DW-1:0]), 64'hDEADBEEF);
        tick();
        idle();
        #1 chk("t2_hold", 64'(rd[2*DW-1:DW]), 64'hDEADBEEF);
        tick();

        // same-address collision, port 0 wins
        we0 = 1; wa0 = 7; wd0 = 1; we1 = 1; wa1 = 7; wd1 = 2; ra_all(7);
        #1 chk("t3_coll_byp", 64'(rd[DW-1:0]), 64'h1);
        tick();
        idle();
        #1 chk("t3_coll_hold", 64'(rd[DW-1:0]), 64'h1);
        tick();
        we1 = 1; wa1 = 7; wd1 = 3;
        #1 chk("t3_p1_byp", 64'(rd[DW-1:0]), 64'h3);
        tick();
        idle();
        #1 chk("t3_p1_hold", 64'(rd[DW-1:0]), 64'h3);
        tick();

        // register 0 hard-wired
        we0 = 1; wa0 = 0; wd0 = '1; iss_valid = 1; iss_wa = 0; ra_all(0);
        #1 chk("t4_r0_byp", 64'(rd[DW-1:0]), 64'h0);
        tick();
        idle();
        #1 chk("t4_r0", 64'(rd[DW-1:0]), 64'h0);
        chk("t4_cnt", 64'(busy_cnt), 64'h0);
        tick();

        // scoreboard set / clear / flush
        iss_valid = 1; iss_wa = 3; tick();
        iss_wa = 4; tick();
        iss_wa = 9; tick();
        idle(); ra_all(3);
        #1 chk("t5_cnt3", 64'(busy_cnt), 64'h3);
        chk("t5_busy3", 64'(rd_busy[0]), 64'h1);
        tick();
        we1 = 1; wa1 = 4; wd1 = 32'h44; ra_all(4);
        #1 chk("t5_wb_busy", 64'(rd_busy[0]), 64'h0);
        tick();
        idle();
        #1 chk("t5_cnt2", 64'(busy_cnt), 64'h2);
        tick();
        flush = 1; iss_valid = 1; iss_wa = 9;
        tick();
        idle(); ra_all(9);
        #1 chk("t5_cnt1", 64'(busy_cnt), 64'h1);
        chk("t5_busy9", 64'(rd_busy[0]), 64'h1);
        tick();

        // mid-sequence reset drops pending write
        we0 = 1; wa0 = 12; wd0 = 55; iss_valid = 1; iss_wa = 10; tick();
        idle();
        rst = 1; we0 = 1; wa0 = 12; wd0 = 77;
        iss_valid = 1; iss_wa = 11; flush = 1;
        tick();
        idle(); ra_all(12);
        #1 chk("t6_rd", 64'(rd[DW-1:0]), 64'h0);
        chk("t6_cnt", 64'(busy_cnt), 64'h0);
        tick();

        // random traffic with address bias toward collisions
        for (int c = 0; c < 600; c++) begin
            int sp;
            sp = ($urandom_range(0, 3) == 0) ? N - 1 : 7;
            rst       = ($urandom_range(0, 99) == 0);
            we0       = $urandom_range(0, 1);
            we1       = $urandom_range(0, 1);
            wa0       = AW'($urandom_range(0, sp));
            wa1       = AW'($urandom_range(0, sp));
            wd0       = $urandom;
            wd1       = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_wa    = AW'($urandom_range(0, sp));
            flush     = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NRD; k++)
                ra[k*AW +: AW] = AW'($urandom_range(0, sp));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
